// File: rtl/pe_array_seq.sv
// rtl/pe_array_seq.sv - weight-load / activation-stream sequencer for a 1-D PE chain
module pe_array_seq #(
  parameter int NUM_PE        = 16,
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8,
  parameter int WGT_PER_PE    = 2,
  parameter int DRAIN_CYC     = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [CNT_WIDTH-1:0]     i_num_vec,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic                     i_wgt_vld,
  input  logic [IN_DATA_WIDTH-1:0] i_wgt_data,
  output logic                     o_wgt_rdy,
  input  logic                     i_act_vld,
  input  logic [IN_DATA_WIDTH-1:0] i_act_data,
  output logic                     o_act_rdy,
  output logic                     o_load_vld,
  output logic [ID_WIDTH-1:0]      o_load_id,
  output logic [IN_DATA_WIDTH-1:0] o_load_data,
  output logic [IN_DATA_WIDTH-1:0] o_left_data,
  output logic                     o_pop_vld,
  output logic [CNT_WIDTH-1:0]     o_vec_cnt
);

  localparam int BEAT_W  = (WGT_PER_PE > 1) ? $clog2(WGT_PER_PE) : 1;
  localparam int DRAIN_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [BEAT_W-1:0]    beat_idx;
  logic [ID_WIDTH-1:0]  pe_idx;
  logic [CNT_WIDTH-1:0] num_vec;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 wgt_hs, act_hs, beat_last, last_wgt, last_act, drain_end;

  assign o_busy    = (state != S_IDLE);
  assign o_done    = (state == S_DONE);
  assign o_wgt_rdy = (state == S_LOAD);
  assign o_act_rdy = (state == S_COMPUTE);

  assign wgt_hs    = i_wgt_vld & o_wgt_rdy;
  assign act_hs    = i_act_vld & o_act_rdy;
  assign beat_last = (beat_idx == BEAT_W'(WGT_PER_PE - 1));
  assign last_wgt  = beat_last && (pe_idx == ID_WIDTH'(NUM_PE - 1));
  assign last_act  = ((o_vec_cnt + CNT_WIDTH'(1)) == num_vec);
  assign drain_end = (drain_cnt == DRAIN_W'(DRAIN_CYC));

  // Abort outranks every other exit from the working states.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (i_abort)                  state_nxt = S_IDLE;
        else if (wgt_hs && last_wgt)  state_nxt = (num_vec == '0) ? S_DRAIN : S_COMPUTE;
      end
      S_COMPUTE: begin
        if (i_abort)                  state_nxt = S_IDLE;
        else if (act_hs && last_act)  state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_abort)                  state_nxt = S_IDLE;
        else if (drain_end)           state_nxt = S_DONE;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beat_idx    <= '0;
      pe_idx      <= '0;
      num_vec     <= '0;
      drain_cnt   <= '0;
      o_load_vld  <= 1'b0;
      o_load_id   <= '0;
      o_load_data <= '0;
      o_left_data <= '0;
      o_pop_vld   <= 1'b0;
      o_vec_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      o_load_vld <= wgt_hs;
      o_pop_vld  <= act_hs;

      if (wgt_hs) begin
        o_load_id   <= pe_idx;
        o_load_data <= i_wgt_data;
        if (beat_last) begin
          beat_idx <= '0;
          if (pe_idx != ID_WIDTH'(NUM_PE - 1)) pe_idx <= pe_idx + 1'b1;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end

      if (act_hs) begin
        o_left_data <= i_act_data;
        if (o_vec_cnt != num_vec) o_vec_cnt <= o_vec_cnt + 1'b1;
      end

      // Counter is zero on the first DRAIN cycle, so DRAIN lasts DRAIN_CYC+1 cycles.
      if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                  drain_cnt <= '0;

      if (state == S_IDLE && i_start) begin
        num_vec   <= i_num_vec;
        beat_idx  <= '0;
        pe_idx    <= '0;
        o_vec_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pe_array_seq.sv
// tb/tb_pe_array_seq.sv - self-checking bench for pe_array_seq
module tb_pe_array_seq;

  localparam int NPE   = 4;
  localparam int WPP   = 2;
  localparam int DRAIN = 8;
  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int IW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_abort;
  logic [CW-1:0] i_num_vec;
  logic          o_busy, o_done;
  logic          i_wgt_vld;
  logic [DW-1:0] i_wgt_data;
  logic          o_wgt_rdy;
  logic          i_act_vld;
  logic [DW-1:0] i_act_data;
  logic          o_act_rdy;
  logic          o_load_vld;
  logic [IW-1:0] o_load_id;
  logic [DW-1:0] o_load_data;
  logic [DW-1:0] o_left_data;
  logic          o_pop_vld;
  logic [CW-1:0] o_vec_cnt;

  pe_array_seq #(
    .NUM_PE(NPE), .ID_WIDTH(IW), .IN_DATA_WIDTH(DW),
    .WGT_PER_PE(WPP), .DRAIN_CYC(DRAIN), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_num_vec(i_num_vec), .o_busy(o_busy), .o_done(o_done),
    .i_wgt_vld(i_wgt_vld), .i_wgt_data(i_wgt_data), .o_wgt_rdy(o_wgt_rdy),
    .i_act_vld(i_act_vld), .i_act_data(i_act_data), .o_act_rdy(o_act_rdy),
    .o_load_vld(o_load_vld), .o_load_id(o_load_id), .o_load_data(o_load_data),
    .o_left_data(o_left_data), .o_pop_vld(o_pop_vld), .o_vec_cnt(o_vec_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: job phase plus counts of accepted beats and vectors.
  // Phases: 0 idle, 1 load, 2 compute, 3 drain, 4 done.
  int            m_phase, m_sent_w, m_drain;
  logic [CW-1:0] m_nv, m_vcnt;
  logic          m_load_vld, m_pop;
  logic [IW-1:0] m_load_id;
  logic [DW-1:0] m_load_data, m_left;

  typedef struct {
    logic [DW-1:0] wdata;
    logic [IW-1:0] exp_id;
    logic [DW-1:0] exp_data;
  } wvec_t;

  typedef struct {
    int nv;
    int wpct;       // 0 selects a strict 1,0,1,0 valid pattern
    int apct;
    int abort_act;  // abort on this activation handshake, 0 = never
    int exp_done;
    int exp_pops;
  } job_t;

  wvec_t wtbl[8];
  job_t  jtbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_sent_w = 0; m_drain = 0; m_nv = '0; m_vcnt = '0;
    m_load_vld = 1'b0; m_pop = 1'b0; m_load_id = '0; m_load_data = '0; m_left = '0;
  endtask

  task automatic model_update();
    logic wh, ah;
    wh = i_wgt_vld && (m_phase == 1);
    ah = i_act_vld && (m_phase == 2);
    m_load_vld = wh;
    m_pop      = ah;
    if (wh) begin
      m_load_id   = IW'(m_sent_w / WPP);
      m_load_data = i_wgt_data;
      m_sent_w++;
    end
    if (ah) begin
      m_left = i_act_data;
      m_vcnt = m_vcnt + 1'b1;
    end
    case (m_phase)
      0: if (i_start) begin
           m_phase = 1; m_nv = i_num_vec; m_sent_w = 0; m_vcnt = '0;
         end
      1: if (i_abort) m_phase = 0;
         else if (wh && m_sent_w == NPE * WPP) begin
           m_phase = (m_nv == 0) ? 3 : 2; m_drain = 0;
         end
      2: if (i_abort) m_phase = 0;
         else if (ah && m_vcnt == m_nv) begin
           m_phase = 3; m_drain = 0;
         end
      3: if (i_abort) m_phase = 0;
         else if (m_drain == DRAIN) m_phase = 4;
         else m_drain++;
      default: m_phase = 0;
    endcase
  endtask

  task automatic cmp_all();
    chk("busy",      32'(o_busy),      32'(m_phase != 0));
    chk("done",      32'(o_done),      32'(m_phase == 4));
    chk("wgt_rdy",   32'(o_wgt_rdy),   32'(m_phase == 1));
    chk("act_rdy",   32'(o_act_rdy),   32'(m_phase == 2));
    chk("load_vld",  32'(o_load_vld),  32'(m_load_vld));
    chk("load_id",   32'(o_load_id),   32'(m_load_id));
    chk("load_data", 32'(o_load_data), 32'(m_load_data));
    chk("pop_vld",   32'(o_pop_vld),   32'(m_pop));
    chk("left_data", 32'(o_left_data), 32'(m_left));
    chk("vec_cnt",   32'(o_vec_cnt),   32'(m_vcnt));
  endtask

  task automatic step(input logic st, input logic ab, input logic wv, input logic [DW-1:0] wd,
                      input logic av, input logic [DW-1:0] ad, input logic [CW-1:0] nv);
    i_start = st; i_abort = ab; i_wgt_vld = wv; i_wgt_data = wd;
    i_act_vld = av; i_act_data = ad; i_num_vec = nv;
    model_update();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic run_to_idle(input int wpct, input int apct, input int abort_act, input logic hold,
                             output int pops, output int done_seen, output int first_id);
    int   cyc, ahs;
    logic wv, av, ab;
    pops = 0; done_seen = 0; first_id = -1; cyc = 0; ahs = 0;
    while (m_phase != 0 && cyc < 3000) begin
      wv = (wpct == 0) ? (cyc % 2 == 0) : ($urandom_range(99) < wpct);
      av = ($urandom_range(99) < apct);
      ab = 1'b0;
      if (m_phase == 2 && av) begin
        ahs++;
        if (ahs == abort_act) ab = 1'b1;
      end
      step(hold, ab, wv, DW'($urandom), av, DW'($urandom), CW'($urandom));
      if (o_pop_vld) pops++;
      if (o_done) done_seen = 1;
      if (o_load_vld && first_id < 0) first_id = int'(o_load_id);
      cyc++;
    end
    if (cyc >= 3000) chk("job_timeout", 32'(1), 32'(0));
  endtask

  initial begin
    int pops, dseen, fid, n;

    for (int i = 0; i < 8; i++) wtbl[i] = '{DW'(i + 1), IW'(i / 2), DW'(i + 1)};
    jtbl[0] = '{2, 0,   100, 0, 1, 2};
    jtbl[1] = '{0, 70,  100, 0, 1, 0};
    jtbl[2] = '{5, 100, 100, 2, 0, 2};
    jtbl[3] = '{7, 60,  40,  0, 1, 7};
    jtbl[4] = '{4, 30,  80,  0, 1, 4};

    rst_n = 1'b0;
    i_start = 0; i_abort = 0; i_num_vec = '0; i_wgt_vld = 0; i_wgt_data = '0;
    i_act_vld = 0; i_act_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_all();

    // Basic job: weights 1..8 back to back, three activations, then drain.
    step(1, 0, 0, 0, 0, 0, CW'(3));
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, wtbl[i].wdata, 0, 0, 0);
      chk("tbl_load_vld",  32'(o_load_vld),  32'(1));
      chk("tbl_load_id",   32'(o_load_id),   32'(wtbl[i].exp_id));
      chk("tbl_load_data", 32'(o_load_data), 32'(wtbl[i].exp_data));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, DW'(8'h10 + i), 0);
      chk("tbl_pop", 32'(o_pop_vld), 32'(1));
      chk("tbl_left", 32'(o_left_data), 32'(8'h10 + i));
    end
    n = 0;
    while (!o_done && n < 50) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    chk("drain_latency", 32'(n), 32'(DRAIN + 1));
    chk("final_vec_cnt", 32'(o_vec_cnt), 32'(3));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("idle_after_done", 32'(o_busy), 32'(0));

    // Table of randomized jobs: toggling weights, zero vectors, abort, stalls.
    for (int j = 0; j < 5; j++) begin
      step(1, 0, 0, 0, 0, 0, CW'(jtbl[j].nv));
      run_to_idle(jtbl[j].wpct, jtbl[j].apct, jtbl[j].abort_act, 1'b0, pops, dseen, fid);
      chk($sformatf("job%0d_done", j), 32'(dseen), 32'(jtbl[j].exp_done));
      chk($sformatf("job%0d_pops", j), 32'(pops),  32'(jtbl[j].exp_pops));
      chk($sformatf("job%0d_first_id", j), 32'(fid), 32'(0));
    end

    // Asynchronous reset between edges in the middle of COMPUTE.
    step(1, 0, 0, 0, 0, 0, CW'(6));
    n = 0;
    while (!(m_phase == 2 && m_vcnt >= 2) && n < 200) begin
      step(0, 0, 1, DW'($urandom), 1, DW'($urandom), 0);
      n++;
    end
    chk("reach_compute", 32'(m_phase == 2), 32'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",      32'(o_busy),      32'(0));
    chk("rst_done",      32'(o_done),      32'(0));
    chk("rst_wgt_rdy",   32'(o_wgt_rdy),   32'(0));
    chk("rst_act_rdy",   32'(o_act_rdy),   32'(0));
    chk("rst_load_vld",  32'(o_load_vld),  32'(0));
    chk("rst_load_id",   32'(o_load_id),   32'(0));
    chk("rst_load_data", 32'(o_load_data), 32'(0));
    chk("rst_left_data", 32'(o_left_data), 32'(0));
    chk("rst_pop_vld",   32'(o_pop_vld),   32'(0));
    chk("rst_vec_cnt",   32'(o_vec_cnt),   32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cmp_all();
    step(1, 0, 0, 0, 0, 0, CW'(3));
    run_to_idle(90, 90, 0, 1'b0, pops, dseen, fid);
    chk("post_rst_done", 32'(dseen), 32'(1));
    chk("post_rst_pops", 32'(pops), 32'(3));

    // Start held high: the next job must begin only from IDLE after done.
    step(1, 0, 0, 0, 0, 0, CW'(2));
    run_to_idle(100, 100, 0, 1'b1, pops, dseen, fid);
    chk("hold_done", 32'(dseen), 32'(1));
    chk("hold_idle_gap", 32'(o_busy), 32'(0));
    step(1, 0, 0, 0, 0, 0, CW'(1));
    chk("hold_restart", 32'(o_busy), 32'(1));
    run_to_idle(100, 100, 0, 1'b0, pops, dseen, fid);
    chk("hold_job2_pops", 32'(pops), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
